pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_pkg.sv | 20 ++
 rtl/pc_redirect_buf.sv | 21 ++
 rtl/pc_fetch.sv | 54 +++++
 tb/tb_pc_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared address-map macros and constants for the fetch stage
`ifndef PC_FETCH_DEFS
`define PC_FETCH_DEFS
`define PC_WORD     32
`define PC_RESET    32'h0000_3000
`define PC_EXC      32'h0000_4180
`define PC_ADDR_LO  32'h0000_3000
`define PC_ADDR_HI  32'h0000_6FFC
`endif

package pc_fetch_pkg;
  localparam int W = `PC_WORD;
  localparam logic [W-1:0] RESET_ADDR = `PC_RESET;
  localparam logic [W-1:0] EXC_ADDR = `PC_EXC;
  localparam logic [W-1:0] ADDR_LO = `PC_ADDR_LO;
  localparam logic [W-1:0] ADDR_HI = `PC_ADDR_HI;
  function automatic logic bad_fetch(input logic [W-1:0] a);
    return (a[1:0] != 2'b00) || (a < ADDR_LO) || (a > ADDR_HI);
  endfunction
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds a redirect target that arrived while fetch was stalled
module pc_redirect_buf
  import pc_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q <= d;
    end
  end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter with jump/branch/exception redirect and stall-deferred targets
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [W-1:0] RESET_PC = RESET_ADDR,
  parameter logic [W-1:0] EXC_PC = EXC_ADDR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         pc_branch,
  input  logic [W-1:0] B_addr,
  input  logic         j_en,
  input  logic [W-1:0] J_addr,
  input  logic         jr_en,
  input  logic [W-1:0] JR_addr,
  input  logic         exc,
  input  logic         eret,
  input  logic [W-1:0] EPC,
  output logic [W-1:0] PC,
  output logic [W-1:0] PC4,
  output logic         AdEL,
  output logic         redirect_pending
);
  logic         redirect_req;
  logic [W-1:0] target;
  logic [W-1:0] buf_target;
  logic [W-1:0] next_pc;
  logic         buf_clear;
  logic         buf_load;
  assign redirect_req = jr_en | j_en | pc_branch;
  assign target = jr_en ? JR_addr : j_en ? J_addr : B_addr;
  assign PC4 = PC + 32'd4;
  assign AdEL = bad_fetch(PC);
  // any unstalled edge either consumes the buffer or supersedes it
  assign buf_clear = exc | eret | ~stall;
  assign buf_load = stall & redirect_req & ~buf_clear;
  pc_redirect_buf u_buf (
    .clk(clk),
    .reset(reset),
    .load(buf_load),
    .clear(buf_clear),
    .d(target),
    .q(buf_target),
    .valid(redirect_pending)
  );
  always_comb begin
    next_pc = exc ? EXC_PC : eret ? EPC : stall ? PC : redirect_req ? target :
              redirect_pending ? buf_target : PC4;
  end
  always_ff @(posedge clk) begin
    PC <= reset ? RESET_PC : next_pc;
  end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed-vector bench for pc_fetch
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        reset, stall, pc_branch, j_en, jr_en, exc, eret;
  logic [31:0] B_addr, J_addr, JR_addr, EPC;
  logic [31:0] PC, PC4;
  logic        AdEL, redirect_pending;
  int vectors = 0;
  int miscompares = 0;

  pc_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_branch(pc_branch), .B_addr(B_addr),
    .j_en(j_en), .J_addr(J_addr), .jr_en(jr_en), .JR_addr(JR_addr), .exc(exc),
    .eret(eret), .EPC(EPC), .PC(PC), .PC4(PC4), .AdEL(AdEL),
    .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    reset = 0; stall = 0; pc_branch = 0; j_en = 0; jr_en = 0; exc = 0; eret = 0;
    B_addr = 0; J_addr = 0; JR_addr = 0; EPC = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    vectors++;
    if (PC !== 32'h3000) begin miscompares++; $display("FAIL reset_pc: got %h want %h", PC, 32'h3000); end
    vectors++;
    if (PC4 !== 32'h3004) begin miscompares++; $display("FAIL reset_pc4: got %h want %h", PC4, 32'h3004); end
    vectors++;
    if (AdEL !== 1'b0 || redirect_pending !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: got adel=%b pend=%b want 0 0", AdEL, redirect_pending);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp [4] = '{32'h3004, 32'h3008, 32'h300C, 32'h3010};
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (PC !== exp[i] || AdEL !== 1'b0) begin
        miscompares++; $display("FAIL seq_%0d: got pc=%h adel=%b want pc=%h adel=0", i, PC, AdEL, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    pc_branch = 1; B_addr = 32'h3100;
    step();
    idle_inputs();
    vectors++;
    if (PC !== 32'h3100) begin miscompares++; $display("FAIL branch: got %h want %h", PC, 32'h3100); end
  endtask

  task automatic test_stall_pending();
    stall = 1; j_en = 1; J_addr = 32'h3300;
    step();
    vectors++;
    if (PC !== 32'h3100 || redirect_pending !== 1'b1) begin
      miscompares++; $display("FAIL stall_1: got pc=%h pend=%b want pc=3100 pend=1", PC, redirect_pending);
    end
    J_addr = 32'h3400;
    step();
    vectors++;
    if (PC !== 32'h3100 || redirect_pending !== 1'b1) begin
      miscompares++; $display("FAIL stall_2: got pc=%h pend=%b want pc=3100 pend=1", PC, redirect_pending);
    end
    idle_inputs();
    step();
    vectors++;
    if (PC !== 32'h3400 || redirect_pending !== 1'b0) begin
      miscompares++; $display("FAIL stall_release: got pc=%h pend=%b want pc=3400 pend=0", PC, redirect_pending);
    end
    step();
    vectors++;
    if (PC !== 32'h3404) begin miscompares++; $display("FAIL after_release: got %h want %h", PC, 32'h3404); end
  endtask

  task automatic test_new_redirect_over_buffer();
    stall = 1; pc_branch = 1; B_addr = 32'h3200;
    step();
    stall = 0; pc_branch = 0; j_en = 1; J_addr = 32'h3240;
    step();
    idle_inputs();
    vectors++;
    if (PC !== 32'h3240 || redirect_pending !== 1'b0) begin
      miscompares++; $display("FAIL new_over_buf: got pc=%h pend=%b want pc=3240 pend=0", PC, redirect_pending);
    end
    step();
    vectors++;
    if (PC !== 32'h3244) begin miscompares++; $display("FAIL new_over_buf_next: got %h want %h", PC, 32'h3244); end
  endtask

  task automatic test_priority();
    jr_en = 1; JR_addr = 32'h3500; j_en = 1; J_addr = 32'h3600; pc_branch = 1; B_addr = 32'h3700;
    step();
    vectors++;
    if (PC !== 32'h3500) begin miscompares++; $display("FAIL prio_jr: got %h want %h", PC, 32'h3500); end
    jr_en = 0;
    step();
    vectors++;
    if (PC !== 32'h3600) begin miscompares++; $display("FAIL prio_j: got %h want %h", PC, 32'h3600); end
    jr_en = 1; exc = 1; pc_branch = 0; stall = 1;
    step();
    idle_inputs();
    vectors++;
    if (PC !== 32'h4180) begin miscompares++; $display("FAIL exc: got %h want %h", PC, 32'h4180); end
    eret = 1; EPC = 32'h3500;
    step();
    idle_inputs();
    vectors++;
    if (PC !== 32'h3500) begin miscompares++; $display("FAIL eret: got %h want %h", PC, 32'h3500); end
  endtask

  task automatic test_exc_clears_pending();
    stall = 1; j_en = 1; J_addr = 32'h3800;
    step();
    j_en = 0; exc = 1;
    step();
    idle_inputs();
    vectors++;
    if (PC !== 32'h4180 || redirect_pending !== 1'b0) begin
      miscompares++; $display("FAIL exc_clear: got pc=%h pend=%b want pc=4180 pend=0", PC, redirect_pending);
    end
    step();
    vectors++;
    if (PC !== 32'h4184) begin miscompares++; $display("FAIL exc_clear_next: got %h want %h", PC, 32'h4184); end
  endtask

  task automatic test_adel();
    logic [31:0] addr [5] = '{32'h3002, 32'h7000, 32'h6FFC, 32'h2FFC, 32'h3000};
    logic        exp  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      jr_en = 1; JR_addr = addr[i];
      step();
      vectors++;
      if (PC !== addr[i] || AdEL !== exp[i]) begin
        miscompares++; $display("FAIL adel_%0d: got pc=%h adel=%b want pc=%h adel=%b", i, PC, AdEL, addr[i], exp[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    jr_en = 1; JR_addr = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    vectors++;
    if (PC4 !== 32'h0 || AdEL !== 1'b1) begin
      miscompares++; $display("FAIL wrap_pc4: got pc4=%h adel=%b want 0 1", PC4, AdEL);
    end
    step();
    vectors++;
    if (PC !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h want 0", PC); end
  endtask

  task automatic test_reset_override();
    jr_en = 1; JR_addr = 32'h3100;
    step();
    jr_en = 0; stall = 1; j_en = 1; J_addr = 32'h3400;
    step();
    vectors++;
    if (redirect_pending !== 1'b1) begin miscompares++; $display("FAIL ro_setup: got pend=%b want 1", redirect_pending); end
    reset = 1; exc = 1; stall = 0;
    step();
    idle_inputs();
    vectors++;
    if (PC !== 32'h3000 || redirect_pending !== 1'b0) begin
      miscompares++; $display("FAIL reset_override: got pc=%h pend=%b want pc=3000 pend=0", PC, redirect_pending);
    end
    step();
    vectors++;
    if (PC !== 32'h3004) begin miscompares++; $display("FAIL reset_override_next: got %h want %h", PC, 32'h3004); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_stall_pending();
    test_new_redirect_over_buffer();
    test_priority();
    test_exc_clears_pending();
    test_adel();
    test_wrap();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
